// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/BLINK/BURST modes timed in
// shared prescaler ticks. Define LED_ACTIVE_LOW_EN to drive the led port active-low.
module led_pattern_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8,
  parameter int PRESC   = 1000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_on,
  input  logic [CNT_W-1:0]   cfg_off,
  input  logic [BURST_W-1:0] cfg_count,
  output logic [NUM_CH-1:0]  led,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  done
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_POL = 1'b1;
`else
  localparam logic LED_POL = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  logic [PW-1:0]      presc_q, presc_d;
  logic               tick_s;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [1:0]         mode_q  [NUM_CH];
  logic [1:0]         mode_d  [NUM_CH];
  logic [CNT_W-1:0]   on_q    [NUM_CH];
  logic [CNT_W-1:0]   on_d    [NUM_CH];
  logic [CNT_W-1:0]   off_q   [NUM_CH];
  logic [CNT_W-1:0]   off_d   [NUM_CH];
  logic [CNT_W-1:0]   timer_q [NUM_CH];
  logic [CNT_W-1:0]   timer_d [NUM_CH];
  logic [BURST_W-1:0] rem_q   [NUM_CH];
  logic [BURST_W-1:0] rem_d   [NUM_CH];
  logic [NUM_CH-1:0]  led_q, led_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  done_q, done_d;

  // Free-running prescaler; never restarted by configuration writes.
  always_comb begin
    tick_s  = (presc_q == PW'(PRESC - 1));
    presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
  end

  // Per-channel next state; a write to a channel overrides any phase or burst end.
  always_comb begin
    logic [CNT_W-1:0] eff_on_v;
    logic [CNT_W-1:0] eff_off_v;
    logic             sel_v;
    eff_on_v  = CNT_ONE;
    eff_off_v = CNT_ONE;
    sel_v     = 1'b0;
    led_d     = {NUM_CH{LED_POL}};
    busy_d    = {NUM_CH{1'b0}};
    done_d    = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      on_d[i]    = on_q[i];
      off_d[i]   = off_q[i];
      timer_d[i] = timer_q[i];
      rem_d[i]   = rem_q[i];
      eff_on_v   = (on_q[i]  == CNT_ZERO) ? CNT_ONE : on_q[i];
      eff_off_v  = (off_q[i] == CNT_ZERO) ? CNT_ONE : off_q[i];
      sel_v      = cfg_we && (int'(cfg_ch) < NUM_CH) && (int'(cfg_ch) == i);

      if (sel_v) begin
        mode_d[i]  = cfg_mode;
        on_d[i]    = cfg_on;
        off_d[i]   = cfg_off;
        timer_d[i] = CNT_ZERO;
        rem_d[i]   = cfg_count;
        case (cfg_mode)
          MODE_BLINK: state_d[i] = ST_ON;
          MODE_BURST: begin
            if (cfg_count != BURST_ZERO) begin
              state_d[i] = ST_ON;
            end else begin
              state_d[i] = ST_IDLE;
              done_d[i]  = 1'b1;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end else if (tick_s) begin
        case (state_q[i])
          ST_ON: begin
            if (timer_q[i] == eff_on_v - CNT_ONE) begin
              state_d[i] = ST_OFF;
              timer_d[i] = CNT_ZERO;
            end else begin
              timer_d[i] = timer_q[i] + CNT_ONE;
            end
          end
          ST_OFF: begin
            if (timer_q[i] == eff_off_v - CNT_ONE) begin
              timer_d[i] = CNT_ZERO;
              if (mode_q[i] == MODE_BURST) begin
                rem_d[i] = rem_q[i] - BURST_ONE;
                if (rem_q[i] == BURST_ONE) begin
                  state_d[i] = ST_IDLE;
                  done_d[i]  = 1'b1;
                end else begin
                  state_d[i] = ST_ON;
                end
              end else begin
                state_d[i] = ST_ON;
              end
            end else begin
              timer_d[i] = timer_q[i] + CNT_ONE;
            end
          end
          default: state_d[i] = state_q[i];
        endcase
      end else begin
        state_d[i] = state_q[i];
      end

      led_d[i]  = LED_POL ^ ((state_d[i] == ST_ON) ||
                             ((state_d[i] == ST_IDLE) && (mode_d[i] == MODE_ON)));
      busy_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_OFF);
    end
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= {PW{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        mode_q[i]  <= MODE_OFF;
        on_q[i]    <= CNT_ONE;
        off_q[i]   <= CNT_ONE;
        timer_q[i] <= CNT_ZERO;
        rem_q[i]   <= BURST_ZERO;
      end
      led_q  <= {NUM_CH{LED_POL}};
      busy_q <= {NUM_CH{1'b0}};
      done_q <= {NUM_CH{1'b0}};
    end else begin
      presc_q <= presc_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        on_q[i]    <= on_d[i];
        off_q[i]   <= off_d[i];
        timer_q[i] <= timer_d[i];
        rem_q[i]   <= rem_d[i];
      end
      led_q  <= led_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (PRESC=1 and PRESC=4) fed the same
// configuration traffic, checked against a tick-count model plus directed tables.
module tb_led_pattern_gen;

  localparam int NCH = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ch = 3'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_on = 16'd0;
  logic [15:0] cfg_off = 16'd0;
  logic [7:0]  cfg_count = 8'd0;
  logic [NCH-1:0] led_a, busy_a, done_a;
  logic [NCH-1:0] led_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_CH(NCH), .CNT_W(16), .BURST_W(8), .PRESC(1)) dut_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_count(cfg_count),
    .led(led_a), .busy(busy_a), .done(done_a));

  led_pattern_gen #(.NUM_CH(NCH), .CNT_W(16), .BURST_W(8), .PRESC(4)) dut_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_count(cfg_count),
    .led(led_b), .busy(busy_b), .done(done_b));

  // Model: per channel, n = ticks elapsed since the last write; the pattern is a
  // function of n, the effective durations and the burst length.
  int m_mode [2][NCH];
  int m_on   [2][NCH];
  int m_off  [2][NCH];
  int m_cnt  [2][NCH];
  int m_n    [2][NCH];
  bit m_done [2][NCH];
  int m_pc   [2];
  int presc_of [2] = '{1, 4};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[d][c] = 0; m_on[d][c] = 1; m_off[d][c] = 1;
        m_cnt[d][c] = 0;  m_n[d][c] = 0;  m_done[d][c] = 1'b0;
      end
    end
  endtask

  task automatic model_edge(input logic we, input int ch, input int mode,
                            input int on, input int off, input int cnt);
    bit tick;
    int per;
    for (int d = 0; d < 2; d++) begin
      tick = (m_pc[d] == presc_of[d] - 1);
      m_pc[d] = tick ? 0 : m_pc[d] + 1;
      for (int c = 0; c < NCH; c++) begin
        m_done[d][c] = 1'b0;
        per = m_on[d][c] + m_off[d][c];
        if (we && ch == c) begin
          m_mode[d][c] = mode;
          m_on[d][c]   = (on == 0) ? 1 : on;
          m_off[d][c]  = (off == 0) ? 1 : off;
          m_cnt[d][c]  = cnt;
          m_n[d][c]    = 0;
          if (mode == 3 && cnt == 0) m_done[d][c] = 1'b1;
        end else if (tick) begin
          if (m_mode[d][c] == 2) begin
            m_n[d][c] = (m_n[d][c] + 1) % per;
          end else if (m_mode[d][c] == 3 && m_n[d][c] < m_cnt[d][c] * per) begin
            m_n[d][c] = m_n[d][c] + 1;
            if (m_n[d][c] == m_cnt[d][c] * per) m_done[d][c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_vec(input string name, input logic [NCH-1:0] act,
                           input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [NCH-1:0] el, eb, ed;
    int per, tot, ph;
    for (int d = 0; d < 2; d++) begin
      el = '0; eb = '0; ed = '0;
      for (int c = 0; c < NCH; c++) begin
        per = m_on[d][c] + m_off[d][c];
        tot = m_cnt[d][c] * per;
        ph  = m_n[d][c] % per;
        ed[c] = m_done[d][c];
        case (m_mode[d][c])
          1: el[c] = 1'b1;
          2: begin eb[c] = 1'b1; el[c] = (ph < m_on[d][c]); end
          3: begin
            eb[c] = (m_n[d][c] < tot);
            el[c] = (m_n[d][c] < tot) && (ph < m_on[d][c]);
          end
          default: el[c] = 1'b0;
        endcase
      end
      if (d == 0) begin
        check_vec("model led_a", led_a, el);
        check_vec("model busy_a", busy_a, eb);
        check_vec("model done_a", done_a, ed);
      end else begin
        check_vec("model led_b", led_b, el);
        check_vec("model busy_b", busy_b, eb);
        check_vec("model done_b", done_b, ed);
      end
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check on the falling edge.
  task automatic cycle(input logic we, input logic [2:0] ch, input logic [1:0] mode,
                       input logic [15:0] on, input logic [15:0] off, input logic [7:0] cnt);
    cfg_we = we; cfg_ch = ch; cfg_mode = mode;
    cfg_on = on; cfg_off = off; cfg_count = cnt;
    @(posedge clk);
    model_edge(we, int'(ch), int'(mode), int'(on), int'(off), int'(cnt));
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  ch;
    logic [1:0]  mode;
    logic [15:0] on;
    logic [15:0] off;
    logic [7:0]  cnt;
    logic [NCH-1:0] led;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int highs, rises;
    logic prev;
    // Expected values are for the PRESC=1 instance, one cycle after each row's inputs.
    tbl[0]  = '{1'b1, 3'd0, 2'd2, 16'd3, 16'd2, 8'd0, 6'b000001, 6'b000001, 6'b000000};
    tbl[1]  = '{1'b1, 3'd1, 2'd3, 16'd1, 16'd1, 8'd2, 6'b000011, 6'b000011, 6'b000000};
    tbl[2]  = '{1'b0, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0, 6'b000001, 6'b000011, 6'b000000};
    tbl[3]  = '{1'b1, 3'd2, 2'd3, 16'd1, 16'd1, 8'd0, 6'b000010, 6'b000011, 6'b000100};
    tbl[4]  = '{1'b0, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0, 6'b000000, 6'b000011, 6'b000000};
    tbl[5]  = '{1'b0, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0, 6'b000001, 6'b000001, 6'b000010};
    tbl[6]  = '{1'b1, 3'd2, 2'd2, 16'd0, 16'd0, 8'd0, 6'b000101, 6'b000101, 6'b000000};
    tbl[7]  = '{1'b1, 3'd6, 2'd1, 16'd5, 16'd5, 8'd0, 6'b000001, 6'b000101, 6'b000000};
    tbl[8]  = '{1'b1, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0, 6'b000100, 6'b000100, 6'b000000};
    tbl[9]  = '{1'b1, 3'd3, 2'd1, 16'd1, 16'd1, 8'd0, 6'b001000, 6'b000100, 6'b000000};
    tbl[10] = '{1'b0, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0, 6'b001100, 6'b000100, 6'b000000};

    model_reset();
    repeat (3) @(negedge clk);
    check_vec("reset led_a", led_a, 6'b000000);
    check_vec("reset busy_a", busy_a, 6'b000000);
    check_vec("reset done_b", done_b, 6'b000000);
    reset = 1'b0;

    for (int r = 0; r < 11; r++) begin
      cycle(tbl[r].we, tbl[r].ch, tbl[r].mode, tbl[r].on, tbl[r].off, tbl[r].cnt);
      check_vec($sformatf("tbl%0d led", r), led_a, tbl[r].led);
      check_vec($sformatf("tbl%0d busy", r), busy_a, tbl[r].busy);
      check_vec($sformatf("tbl%0d done", r), done_a, tbl[r].done);
    end

    // Write landing on the burst-ending tick must suppress done.
    cycle(1'b1, 3'd4, 2'd3, 16'd1, 16'd1, 8'd1);
    cycle(1'b0, 3'd0, 2'd0, 16'd0, 16'd0, 8'd0);
    cycle(1'b1, 3'd4, 2'd0, 16'd1, 16'd1, 8'd0);
    check_vec("burst end overridden done", {5'd0, done_a[4]}, 6'd0);
    check_vec("burst end overridden busy", {5'd0, busy_a[4]}, 6'd0);

    // PRESC=4, BLINK 2/2 on ch3 while ch0 blinks alongside: period 16, 8 high.
    cycle(1'b1, 3'd0, 2'd2, 16'd1, 16'd3, 8'd0);
    cycle(1'b1, 3'd3, 2'd2, 16'd2, 16'd2, 8'd0);
    idle(16);
    highs = 0; rises = 0; prev = led_b[3];
    for (int k = 0; k < 32; k++) begin
      idle(1);
      if (led_b[3]) highs++;
      if (led_b[3] && !prev) rises++;
      prev = led_b[3];
    end
    check_vec("presc4 high cycles", 6'(highs), 6'd16);
    check_vec("presc4 rising edges", 6'(rises), 6'd2);

    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(3) == 0)
        cycle(1'b1, 3'($urandom_range(7)), 2'($urandom_range(3)),
              16'($urandom_range(4)), 16'($urandom_range(4)), 8'($urandom_range(3)));
      else
        idle(1);
    end

    // Asynchronous reset in the middle of activity.
    cycle(1'b1, 3'd1, 2'd2, 16'd3, 16'd3, 8'd0);
    cycle(1'b1, 3'd5, 2'd1, 16'd3, 16'd3, 8'd0);
    cfg_we = 1'b0;
    reset = 1'b1;
    #1;
    check_vec("async reset led_a", led_a, 6'b000000);
    check_vec("async reset busy_a", busy_a, 6'b000000);
    check_vec("async reset led_b", led_b, 6'b000000);
    check_vec("async reset busy_b", busy_b, 6'b000000);
    check_vec("async reset done_a", done_a, 6'b000000);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(10);
    check_vec("post reset idle led", led_a | led_b, 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
